// File: rtl/trng_cond_pkg.sv
// Shared types and default constants for the TRNG conditioning stage.
// Defining TRNG_COND_VN_EN elsewhere enables von Neumann debiasing in trng_conditioner.
package trng_cond_pkg;

   typedef enum logic {
      PAIR_EMPTY = 1'b0,
      PAIR_HALF  = 1'b1
   } pair_state_e;

   localparam int unsigned WIDTH_DEF      = 8;
   localparam int unsigned RCT_LIMIT_DEF  = 32;
   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam int unsigned DROP_CNT_W     = 8;

endpackage

// File: rtl/trng_cond_fifo.sv
// Pointer-based synchronous FIFO with a registered head word and a valid/ready output side.
// The extra pointer bit tells full from empty.
module trng_cond_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]    wr_ptr, rd_ptr, wr_next, rd_next;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] data_next;
   logic             pop_c, push_c;

   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_c  = out_valid && out_ready;
   assign push_c = push && !flush && (!full || pop_c);

   // Next head word; a push into the slot that becomes the head is forwarded.
   always_comb begin
      wr_next   = wr_ptr + PW'(push_c);
      rd_next   = rd_ptr + PW'(pop_c);
      data_next = mem[rd_next[AW-1:0]];
      if (push_c && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
         data_next = push_data;
      end
      if (flush) begin
         wr_next   = '0;
         rd_next   = '0;
         data_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         wr_ptr    <= wr_next;
         rd_ptr    <= rd_next;
         out_data  <= data_next;
         out_valid <= (wr_next != rd_next);
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/trng_conditioner.sv
// Repetition-count health test, optional von Neumann debias, word packer and output FIFO.
// Build option: define TRNG_COND_VN_EN to enable the von Neumann pair stage.
module trng_conditioner
   import trng_cond_pkg::*;
#(
   parameter int unsigned WIDTH      = WIDTH_DEF,
   parameter int unsigned RCT_LIMIT  = RCT_LIMIT_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  raw_bit,
   input  logic                  raw_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  health_fail,
   input  logic                  fail_clear,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam int unsigned RUN_W = 8;
   localparam int unsigned CNT_W = $clog2(WIDTH);

   logic [RUN_W-1:0] run_cnt, run_next_c;
   logic             prev_bit;
   logic             accept_c, trip_c, take_c, clr_c, flush_c;
   logic             emit_c, emit_bit_c;
   logic [CNT_W-1:0] pack_cnt;
   logic [WIDTH-1:0] pack_word, word_c, push_word;
   logic             push_q;
   logic             fifo_full, fifo_empty, drop_c;

   assign accept_c = raw_valid && !health_fail && !fail_clear;
   assign clr_c    = fail_clear || health_fail;
   assign flush_c  = trip_c || health_fail;

   // Run length of identical raw bits; zero means no previous bit.
   always_comb begin
      run_next_c = RUN_W'(1);
      if ((run_cnt != '0) && (raw_bit == prev_bit)) begin
         run_next_c = (run_cnt == RUN_W'(RCT_LIMIT)) ? run_cnt : run_cnt + RUN_W'(1);
      end
   end

   assign trip_c = accept_c && (run_next_c == RUN_W'(RCT_LIMIT));
   assign take_c = accept_c && !trip_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt     <= '0;
         prev_bit    <= 1'b0;
         health_fail <= 1'b0;
      end else if (fail_clear) begin
         run_cnt     <= '0;
         health_fail <= 1'b0;
      end else if (accept_c) begin
         run_cnt  <= run_next_c;
         prev_bit <= raw_bit;
         if (trip_c) begin
            health_fail <= 1'b1;
         end
      end
   end

`ifdef TRNG_COND_VN_EN
   pair_state_e pair_state, pair_next;
   logic        pair_bit;

   always_ff @(posedge clk) begin
      if (rst || clr_c) begin
         pair_state <= PAIR_EMPTY;
         pair_bit   <= 1'b0;
      end else begin
         pair_state <= pair_next;
         if (take_c && (pair_state == PAIR_EMPTY)) begin
            pair_bit <= raw_bit;
         end
      end
   end

   // Unequal pairs emit their first bit; 00 and 11 are discarded.
   always_comb begin
      pair_next  = pair_state;
      emit_c     = 1'b0;
      emit_bit_c = pair_bit;
      case (pair_state)
         PAIR_EMPTY: if (take_c) pair_next = PAIR_HALF;
         PAIR_HALF: begin
            if (take_c) begin
               pair_next = PAIR_EMPTY;
               emit_c    = (pair_bit != raw_bit);
            end
         end
         default: pair_next = PAIR_EMPTY;
      endcase
   end
`else
   assign emit_c     = take_c;
   assign emit_bit_c = raw_bit;
`endif

   assign word_c = pack_word | (WIDTH'(emit_bit_c) << pack_cnt);

   // LSB-first packer; the finished word is staged one edge before the FIFO push.
   always_ff @(posedge clk) begin
      if (rst) begin
         pack_cnt  <= '0;
         pack_word <= '0;
         push_q    <= 1'b0;
         push_word <= '0;
      end else begin
         push_q <= 1'b0;
         if (clr_c) begin
            pack_cnt  <= '0;
            pack_word <= '0;
         end else if (emit_c) begin
            if (pack_cnt == CNT_W'(WIDTH - 1)) begin
               push_q    <= 1'b1;
               push_word <= word_c;
               pack_cnt  <= '0;
               pack_word <= '0;
            end else begin
               pack_word <= word_c;
               pack_cnt  <= pack_cnt + CNT_W'(1);
            end
         end
      end
   end

   trng_cond_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_c),
      .push      (push_q),
      .push_data (push_word),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign drop_c = push_q && fifo_full && !flush_c && !(out_valid && out_ready && !fifo_empty);

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (drop_c && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
   end

endmodule
